// File: rtl/mem_dma_pkg.sv
// Shared types and constants for the block-copy DMA engine.
// Bank geometry here must track the unified memory it drives.
package mem_dma_pkg;

   localparam int unsigned NUM_BANKS = 4;
   localparam int unsigned DEPTH [NUM_BANKS] = '{1024, 32, 1024, 750};

   typedef enum logic [2:0] {
      StIdle,
      StPrime,
      StStream,
      StDrain,
      StDone,
      StReject
   } state_e;

   // Sums done in 32 bits, so addr+len can never wrap.
   function automatic logic fits(input int unsigned addr, input int unsigned len,
                                 input int unsigned depth);
      return (addr + len) <= depth;
   endfunction

endpackage

// File: rtl/mem_lane_drv.sv
// Steers one address/data/write-enable triple onto the selected bank lane.
// Every lane that is not selected drives zero.
module mem_lane_drv
   import mem_dma_pkg::*;
#(
   parameter int unsigned WIDTH  = 36,
   parameter int unsigned ADDR_W = 10
) (
   input  logic                       i_en,
   input  logic                       i_we,
   input  logic [1:0]                 i_bank,
   input  logic [ADDR_W-1:0]          i_addr,
   input  logic [WIDTH-1:0]           i_data,
   output logic [WIDTH*NUM_BANKS-1:0] o_a,
   output logic [WIDTH*NUM_BANKS-1:0] o_wd,
   output logic [NUM_BANKS-1:0]       o_we
);

   always_comb begin
      o_a  = '0;
      o_wd = '0;
      o_we = '0;
      for (int k = 0; k < NUM_BANKS; k++) begin
         if (i_en && (i_bank == 2'(k))) begin
            o_a[WIDTH*k +: WIDTH]  = WIDTH'(i_addr);
            o_wd[WIDTH*k +: WIDTH] = i_we ? i_data : '0;
            o_we[k]                = i_we;
         end
      end
   end

endmodule

// File: rtl/mem_dma_engine.sv
// Block-copy engine: streams one word per cycle from a source bank to a
// different destination bank through combinational-read/sync-write lanes.
module mem_dma_engine
   import mem_dma_pkg::*;
#(
   parameter int unsigned WIDTH  = 36,
   parameter int unsigned ADDR_W = 10,
   parameter int unsigned LEN_W  = 11
) (
   input  logic                       i_clk,
   input  logic                       i_rst_n,
   input  logic                       i_start,
   input  logic [1:0]                 i_src_bank,
   input  logic [1:0]                 i_dst_bank,
   input  logic [ADDR_W-1:0]          i_src_addr,
   input  logic [ADDR_W-1:0]          i_dst_addr,
   input  logic [LEN_W-1:0]           i_len,
   output logic                       o_busy,
   output logic                       o_done,
   output logic                       o_err,
   output logic [NUM_BANKS-1:0]       o_mem_we,
   output logic [WIDTH*NUM_BANKS-1:0] o_mem_a,
   output logic [WIDTH*NUM_BANKS-1:0] o_mem_wd,
   input  logic [WIDTH*NUM_BANKS-1:0] i_mem_rd
);

   state_e                     r_state, w_state_nxt;
   logic [1:0]                 r_src_bank, r_dst_bank;
   logic [ADDR_W-1:0]          r_src_addr, r_dst_addr, w_rd_addr, w_wr_addr;
   logic [LEN_W-1:0]           r_len, r_cnt, w_cnt_inc;
   logic [WIDTH-1:0]           r_data, w_src_word;
   logic                       r_err, w_reject, w_rd_en, w_wr_en;
   logic [WIDTH*NUM_BANKS-1:0] w_rd_a, w_rd_wd, w_wr_a, w_wr_wd;
   logic [NUM_BANKS-1:0]       w_rd_we, w_wr_we;

   always_comb begin
      w_reject = (i_src_bank == i_dst_bank) || (i_len == '0)
               || !fits(32'(i_src_addr), 32'(i_len), DEPTH[i_src_bank])
               || !fits(32'(i_dst_addr), 32'(i_len), DEPTH[i_dst_bank]);
   end

   // r_cnt is the source word index; the write side trails it by one.
   assign w_cnt_inc = r_cnt + LEN_W'(1);
   assign w_rd_addr = r_src_addr + r_cnt[ADDR_W-1:0];
   assign w_wr_addr = r_dst_addr + r_cnt[ADDR_W-1:0] - ADDR_W'(1);

   always_comb begin
      w_src_word = '0;
      for (int k = 0; k < NUM_BANKS; k++) begin
         if (r_src_bank == 2'(k)) w_src_word = i_mem_rd[WIDTH*k +: WIDTH];
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= StIdle;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         StIdle:            if (i_start) w_state_nxt = w_reject ? StReject : StPrime;
         StPrime, StStream: w_state_nxt = (w_cnt_inc == r_len) ? StDrain : StStream;
         StDrain:           w_state_nxt = StDone;
         StDone, StReject:  w_state_nxt = StIdle;
         default:           w_state_nxt = StIdle;
      endcase
   end

   always_comb begin
      o_busy  = 1'b0;
      o_done  = 1'b0;
      w_rd_en = 1'b0;
      w_wr_en = 1'b0;
      unique case (r_state)
         StPrime:          begin o_busy = 1'b1; w_rd_en = 1'b1; end
         StStream:         begin o_busy = 1'b1; w_rd_en = 1'b1; w_wr_en = 1'b1; end
         StDrain:          begin o_busy = 1'b1; w_wr_en = 1'b1; end
         StDone, StReject: o_done = 1'b1;
         default:          ;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_src_bank <= '0;
         r_dst_bank <= '0;
         r_src_addr <= '0;
         r_dst_addr <= '0;
         r_len      <= '0;
         r_cnt      <= '0;
         r_data     <= '0;
         r_err      <= 1'b0;
      end else begin
         if ((r_state == StIdle) && i_start) begin
            r_err <= w_reject;
            if (!w_reject) begin
               r_src_bank <= i_src_bank;
               r_dst_bank <= i_dst_bank;
               r_src_addr <= i_src_addr;
               r_dst_addr <= i_dst_addr;
               r_len      <= i_len;
               r_cnt      <= '0;
            end
         end else if (o_busy) begin
            r_cnt <= w_cnt_inc;
         end
         if (w_rd_en) r_data <= w_src_word;
      end
   end

   mem_lane_drv #(
      .WIDTH (WIDTH),
      .ADDR_W(ADDR_W)
   ) u_rd_lane (
      .i_en  (w_rd_en),
      .i_we  (1'b0),
      .i_bank(r_src_bank),
      .i_addr(w_rd_addr),
      .i_data('0),
      .o_a   (w_rd_a),
      .o_wd  (w_rd_wd),
      .o_we  (w_rd_we)
   );

   mem_lane_drv #(
      .WIDTH (WIDTH),
      .ADDR_W(ADDR_W)
   ) u_wr_lane (
      .i_en  (w_wr_en),
      .i_we  (1'b1),
      .i_bank(r_dst_bank),
      .i_addr(w_wr_addr),
      .i_data(r_data),
      .o_a   (w_wr_a),
      .o_wd  (w_wr_wd),
      .o_we  (w_wr_we)
   );

   // Source and destination banks always differ, so the OR never collides.
   assign o_mem_a  = w_rd_a  | w_wr_a;
   assign o_mem_wd = w_rd_wd | w_wr_wd;
   assign o_mem_we = w_rd_we | w_wr_we;
   assign o_err    = r_err;

endmodule

// File: doc/mem_dma_engine.md
Name: mem_dma_engine

Overview:
- Initiator-side block-copy engine driving the four-bank unified memory: bank0 1024x24, bank1 32x36, bank2 1024x5, bank3 750x36.
- Accepts a copy command from the control path and reads words from one bank while writing them to another.
- Produces a one-word-per-cycle pipelined stream through the memory's combinational-read / synchronous-write lanes.
- Sits beside the pipeline MEM stage and shares the memory lanes through an external mux, which is not part of this block.

Parameters:
- WIDTH, 36, lane width of each memory bank port (address and data).
- ADDR_W, 10, internal address width; zero-extended onto a WIDTH lane.
- LEN_W, 11, transfer length width (max 1024 words).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  command strobe; sampled only in IDLE.
- src_bank  in  2  source bank index.
- dst_bank  in  2  destination bank index.
- src_addr  in  ADDR_W  first source word.
- dst_addr  in  ADDR_W  first destination word.
- len  in  LEN_W  word count.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle completion pulse.
- err  out  1  sticky command-rejected flag.
- mem_we  out  4  per-bank write enables.
- mem_a  out  WIDTH*4  per-bank addresses; lane k = bits [WIDTH*(k+1)-1:WIDTH*k].
- mem_wd  out  WIDTH*4  per-bank write data.
- mem_rd  in  WIDTH*4  per-bank read data, combinational from mem_a.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - busy=0, done=0, err=0, mem_we=0, mem_a=0, mem_wd=0.
  - Counters and data register are cleared.
  - Reset mid-transfer aborts immediately with no further writes; destination words already written remain.
- Lanes not addressed in the current cycle drive 0 on mem_a and mem_wd, and 0 on their mem_we bit.
- Command check, performed in the IDLE cycle where start=1; the command is rejected if any of these hold:
  - src_bank==dst_bank.
  - len==0.
  - src_addr+len > DEPTH[src_bank].
  - dst_addr+len > DEPTH[dst_bank].
  - Sums are computed LEN_W+1 bits wide, so no wrap-around.
  - An exact fit (addr+len==DEPTH) is accepted.
- Rejection: the next cycle has done=1, err=1, busy=0, and no memory traffic. err stays 1 until the next accepted start clears it.
- Acceptance: clears err and latches all command fields. States are:
  - PRIME (1 cycle): drive src lane address = src_addr; the data register captures the src lane of mem_rd at the clock edge.
  - STREAM (len-1 cycles, skipped when len=1): in cycle i (i=1..len-1), read src_addr+i and simultaneously write dst_addr+i-1 with the data register. mem_we[dst_bank]=1, and the data register reloads at the edge.
  - DRAIN (1 cycle): write dst_addr+len-1 with the data register.
  - DONE (1 cycle): done=1, busy=0, then return to IDLE.
- busy=1 in PRIME, STREAM and DRAIN.
- Total: start edge to done pulse is len+2 cycles; exactly len write cycles, one per destination word, in ascending order.
- Width rules:
  - Data is moved as full WIDTH lanes; narrow banks (24b, 5b) return zero-extended data.
  - Writes into narrow banks truncate in the memory; the engine does no masking.
- start while busy or in DONE is ignored, with no queuing.
- Command inputs are don't-care outside the IDLE start cycle.

Decomposition:
- Package mem_dma_pkg holds:
  - the state enum (IDLE, PRIME, STREAM, DRAIN, DONE, REJECT);
  - the bank depth constant array DEPTH = {1024, 32, 1024, 750};
  - NUM_BANKS=4.
- Sub-module mem_lane_drv, purely combinational: given bank index, address, data and a write flag, it produces the WIDTH*4 address/data vectors and the 4-bit we vector with all other lanes zeroed. Two instances are used: one for read and one for write, ORed lane-wise. The banks differ, so the lanes never overlap.

Test Plan:
- Basic copy:
  - Stimulus: bank0 words 0..3 preloaded with 24'h000011..000014; start with src_bank=0, dst_bank=2, src_addr=0, dst_addr=10, len=4.
  - Expected: busy for 5 cycles; mem_we=4'b0100 on 4 consecutive cycles at addresses 10..13; bank2 holds 5'h11..5'h14; done pulses 6 cycles after start; err=0.
- Single word:
  - Stimulus: src_bank=3, dst_bank=1, src_addr=749, dst_addr=31, len=1 (exact fit at both ends).
  - Expected: PRIME then DRAIN; a single write to bank1 addr 31 with value bank3[749]; done pulses 3 cycles after start.
- Rejections, each with no mem_we activity and done+err one cycle after start:
  - src_bank=dst_bank=2;
  - len=0;
  - src_bank=1, src_addr=30, len=4.
  - Expected: err stays high until a following valid start, which clears it.
- Start during transfer: start asserted with new fields while busy.
  - Expected: ignored; the original transfer completes unchanged; no second done.
- Reset mid-stream:
  - Stimulus: len=8 copy; rst_n low during the 3rd STREAM cycle.
  - Expected: all outputs 0 immediately; only the writes already done persist; after rst_n high, a fresh len=2 copy completes normally.
